irq_pending_arbiter: RTL and testbench
======================================

// Module: irq_pending_arbiter
// PURPOSE
//  Latches rising edges on N request lines into a pending register and gates them with a mask.
//  Selects the highest-priority pending line (bit N-1 highest) and presents its index.
//  Presentation uses a valid/ready handshake; the pending bit clears on acceptance.
//  Sits upstream of the priority-encode path and turns raw request wires into a registered,
//  flow-controlled interrupt index stream.
// PARAMETERS
//  N      8  number of request lines
//  IDX_W  3  index width; must equal $clog2(N)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active-low
//  req        in   N      raw request lines, level; a 0->1 transition is an event
//  mask       in   N      1 = line enabled for arbitration; pending bits still latch while masked
//  irq_valid  out  1      irq_idx holds a valid selection
//  irq_idx    out  IDX_W  index of the selected line; 7 = bit 7
//  irq_ready  in   1      consumer accepts when irq_valid & irq_ready at a clk edge
//  pending    out  N      current pending register, for status readback
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - pending=0, irq_valid=0, irq_idx=0, state=IDLE.
//   - req_q=all-ones, so lines already high at release produce no event.
//  Reset mid-handshake drops the presented request; it is not re-presented.
//  Edge detect: edge = req & ~req_q; req_q <= req every cycle.
//  Pending update each edge: pending <= (pending & ~clr) | edge.
//   - clr = onehot(irq_idx) on a handshake cycle, else 0.
//   - A new edge on the bit being cleared in the same cycle wins; the bit stays set.
//   - Multiple simultaneous edges all latch. Repeated edges on an already-set bit are absorbed.
//  Selection: sel = highest set bit of (pending & mask), computed combinationally.
//  FSM IDLE:
//   - If (pending & mask) != 0: irq_idx <= sel, irq_valid <= 1, go PRESENT.
//   - Else hold with irq_valid=0.
//  FSM PRESENT:
//   - irq_idx and irq_valid are held stable until handshake.
//   - Later higher-priority edges or mask changes do not alter or withdraw the presented index.
//   - On irq_valid & irq_ready: clear pending[irq_idx], irq_valid <= 0, go IDLE.
//  Latency:
//   - req rises before edge k -> pending set after edge k -> irq_valid=1 after edge k+1.
//   - After a handshake, irq_valid stays low for at least 1 cycle before the next presentation.
//   - Back-to-back throughput is therefore 1 index per 2 cycles.
//  irq_ready while irq_valid=0 is ignored.
//  Width rules:
//   - irq_idx is zero-extended position, range 0..N-1.
//   - No output is X after reset; all state is reset.
// STRUCTURE
//  Package irq_arb_pkg holds:
//   - localparams N=8 and IDX_W=3.
//   - typedef enum {IDLE, PRESENT} arb_state_t.
//   - function onehot(idx) returning N bits.
//  Sub-module prio_enc_n (combinational, parameter N): in[N-1:0] -> idx[IDX_W-1:0], any.
//   - Highest set bit wins; idx=0 when none set.
//   - The top level instantiates it once on (pending & mask).
//  Top level contains req_q, the pending register, the FSM and the output registers only.
// TESTING
//  1. Reset with req=8'hFF held through release.
//     -> pending=0 and irq_valid=0 for 5 cycles; no event from lines already high.
//  2. req 0x00->0x04, mask=0xFF, irq_ready=0.
//     -> irq_valid=1 and irq_idx=2 two edges later, held 10 cycles.
//     -> Raise ready: pending=0x00 next cycle, irq_valid=0.
//  3. Same-cycle edges on bits 1, 5, 6 with ready=1.
//     -> indices presented in order 6, 5, 1, each valid for 1 cycle with gaps; pending ends 0x00.
//  4. mask=0x0F with an edge on bit 7, then an edge on bit 3.
//     -> only idx=3 presented; pending=0x80 remains.
//     -> Set mask=0xFF: idx=7 presented next.
//  5. Bit 4 presented; pulse bit 4 low->high so its edge lands on the handshake cycle.
//     -> pending[4] stays 1; idx=4 re-presented.
//  6. Bit 2 presented, then rst_n=0 for 1 cycle.
//     -> irq_valid=0, pending=0 next cycle; nothing presented afterwards.

Source files
------------

// File: rtl/irq_arb_pkg.sv
// rtl/irq_arb_pkg.sv - shared sizes, FSM state type and helpers for the irq pending arbiter
package irq_arb_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_t;

    // One-hot N-bit vector with bit idx set; used to clear the accepted pending bit.
    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// rtl/prio_enc_n.sv - combinational highest-set-bit priority encoder
//
// Purpose: returns the position of the highest set bit of in; idx=0 when none set.
// Ports:
//   in   in   N      candidate bits, bit N-1 has highest priority
//   idx  out  IDX_W  position of the highest set bit
//   any  out  1      at least one bit of in is set
module prio_enc_n #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     in,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan: a later (higher) set bit overwrites earlier ones.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (in[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |in;

endmodule

// File: rtl/irq_pending_arbiter.sv
// rtl/irq_pending_arbiter.sv - edge-latched, masked, priority-selected interrupt index stream
//
// Purpose: latches 0->1 transitions on req into pending, selects the highest enabled
// pending line and presents its index with a valid/ready handshake; the pending bit
// clears when the index is accepted.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active-low
//   req        in   N      raw level request lines
//   mask       in   N      1 = line may be selected; pending still latches when 0
//   irq_valid  out  1      irq_idx holds a valid selection
//   irq_idx    out  IDX_W  selected line index
//   irq_ready  in   1      consumer accepts on irq_valid & irq_ready
//   pending    out  N      pending register for status readback
module irq_pending_arbiter
    import irq_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_idx,
    input  logic             irq_ready,
    output logic [N-1:0]     pending
);

    arb_state_t       state;
    logic [N-1:0]     req_q;
    logic [N-1:0]     req_edge;
    logic [N-1:0]     clr;
    logic             handshake;
    logic [IDX_W-1:0] sel;
    logic             sel_any;

    assign req_edge  = req & ~req_q;
    assign handshake = irq_valid & irq_ready;
    assign clr       = handshake ? onehot(irq_idx) : '0;

    prio_enc_n #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .in  (pending & mask),
        .idx (sel),
        .any (sel_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // All-ones history: lines already high when reset releases are not events.
            req_q     <= '1;
            pending   <= '0;
            irq_valid <= 1'b0;
            irq_idx   <= '0;
            state     <= IDLE;
        end else begin
            req_q   <= req;
            // OR-ing the edge after the clear lets a new edge on the accepted bit win.
            pending <= (pending & ~clr) | req_edge;
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        irq_idx   <= sel;
                        irq_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    // Index is frozen until accepted, regardless of new edges or mask.
                    if (irq_ready) begin
                        irq_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    irq_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// tb/tb_irq_pending_arbiter.sv - self-checking bench for irq_pending_arbiter
module tb_irq_pending_arbiter;
    import irq_arb_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N-1:0]     mask;
    logic             irq_valid;
    logic [IDX_W-1:0] irq_idx;
    logic             irq_ready;
    logic [N-1:0]     pending;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit [N-1:0] m_prev;
    bit [N-1:0] m_pend;
    bit         m_valid;
    int         m_idx;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] mask;
        logic         ready;
        logic         exp_valid;
        int           exp_idx;
        logic [N-1:0] exp_pend;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    irq_pending_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .irq_valid (irq_valid),
        .irq_idx   (irq_idx),
        .irq_ready (irq_ready),
        .pending   (pending)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: one call per clock edge, using the inputs present at that edge.
    task automatic model_edge();
        bit [N-1:0] events;
        bit [N-1:0] old_pend;
        bit         accepted;
        int         best;
        if (!rst_n) begin
            m_prev  = '1;
            m_pend  = '0;
            m_valid = 0;
            m_idx   = 0;
            return;
        end
        events   = req & ~m_prev;
        old_pend = m_pend;
        accepted = m_valid && irq_ready;
        for (int i = 0; i < N; i++) begin
            if (events[i]) m_pend[i] = 1;
            else if (accepted && i == m_idx) m_pend[i] = 0;
        end
        if (accepted) begin
            m_valid = 0;
        end else if (!m_valid) begin
            best = -1;
            for (int i = N - 1; i >= 0; i--)
                if (best < 0 && old_pend[i] && mask[i]) best = i;
            if (best >= 0) begin
                m_valid = 1;
                m_idx   = best;
            end
        end
        m_prev = req;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_valid", int'(irq_valid), int'(m_valid));
        chk("model_pending", int'(pending), int'(m_pend));
        if (m_valid) chk("model_idx", int'(irq_idx), m_idx);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 8'hFF;
        mask      = 8'hFF;
        irq_ready = 1'b0;
        m_prev    = '1;
        m_pend    = '0;
        m_valid   = 0;
        m_idx     = 0;

        // 1. reset with all lines high through release
        step();
        step();
        chk("rst_idx", int'(irq_idx), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_valid", int'(irq_valid), 0);
            chk("t1_pending", int'(pending), 0);
        end

        // 2. single edge on bit 2, stalled consumer
        req = 8'h00;
        step();
        req = 8'h04;
        step();
        chk("t2_pend_latched", int'(pending), 8'h04);
        chk("t2_not_yet_valid", int'(irq_valid), 0);
        step();
        chk("t2_valid", int'(irq_valid), 1);
        chk("t2_idx", int'(irq_idx), 2);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_hold_valid", int'(irq_valid), 1);
            chk("t2_hold_idx", int'(irq_idx), 2);
        end
        irq_ready = 1'b1;
        step();
        chk("t2_acc_pending", int'(pending), 0);
        chk("t2_acc_valid", int'(irq_valid), 0);

        // 3. simultaneous edges on bits 1,5,6 with ready held high (table)
        req = 8'h00;
        step();
        step();
        vecs[0] = '{8'h62, 8'hFF, 1'b1, 1'b0, 0, 8'h62};
        vecs[1] = '{8'h62, 8'hFF, 1'b1, 1'b1, 6, 8'h62};
        vecs[2] = '{8'h62, 8'hFF, 1'b1, 1'b0, 0, 8'h22};
        vecs[3] = '{8'h62, 8'hFF, 1'b1, 1'b1, 5, 8'h22};
        vecs[4] = '{8'h62, 8'hFF, 1'b1, 1'b0, 0, 8'h02};
        vecs[5] = '{8'h62, 8'hFF, 1'b1, 1'b1, 1, 8'h02};
        vecs[6] = '{8'h62, 8'hFF, 1'b1, 1'b0, 0, 8'h00};
        vecs[7] = '{8'h62, 8'hFF, 1'b1, 1'b0, 0, 8'h00};
        foreach (vecs[k]) begin
            req       = vecs[k].req;
            mask      = vecs[k].mask;
            irq_ready = vecs[k].ready;
            step();
            chk($sformatf("t3_valid[%0d]", k), int'(irq_valid), int'(vecs[k].exp_valid));
            chk($sformatf("t3_pending[%0d]", k), int'(pending), int'(vecs[k].exp_pend));
            if (vecs[k].exp_valid)
                chk($sformatf("t3_idx[%0d]", k), int'(irq_idx), vecs[k].exp_idx);
        end

        // 4. masked bit 7 stays pending while bit 3 is served
        req = 8'h00; mask = 8'h0F; irq_ready = 1'b0;
        step();
        req = 8'h80;
        step();
        step();
        chk("t4_masked_no_valid", int'(irq_valid), 0);
        chk("t4_masked_pending", int'(pending), 8'h80);
        req = 8'h88;
        step();
        step();
        chk("t4_idx3_valid", int'(irq_valid), 1);
        chk("t4_idx3", int'(irq_idx), 3);
        irq_ready = 1'b1;
        step();
        chk("t4_after_acc", int'(pending), 8'h80);
        irq_ready = 1'b0;
        step();
        step();
        chk("t4_still_masked", int'(irq_valid), 0);
        mask = 8'hFF;
        step();
        chk("t4_idx7_valid", int'(irq_valid), 1);
        chk("t4_idx7", int'(irq_idx), 7);
        irq_ready = 1'b1;
        step();
        chk("t4_final_pending", int'(pending), 0);

        // 5. new edge on the bit being accepted keeps it pending
        req = 8'h00; irq_ready = 1'b0;
        step();
        req = 8'h10;
        step();
        step();
        chk("t5_idx4", int'(irq_idx), 4);
        req = 8'h00;
        step();
        req = 8'h10; irq_ready = 1'b1;
        step();
        chk("t5_pend_kept", int'(pending), 8'h10);
        chk("t5_gap", int'(irq_valid), 0);
        irq_ready = 1'b0;
        step();
        chk("t5_repres_valid", int'(irq_valid), 1);
        chk("t5_repres_idx", int'(irq_idx), 4);
        irq_ready = 1'b1;
        step();
        chk("t5_final_pending", int'(pending), 0);

        // 6. reset while presenting drops the request
        req = 8'h00; irq_ready = 1'b0;
        step();
        req = 8'h04;
        step();
        step();
        chk("t6_presented", int'(irq_valid), 1);
        rst_n = 1'b0;
        step();
        chk("t6_rst_valid", int'(irq_valid), 0);
        chk("t6_rst_pending", int'(pending), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_quiet", int'(irq_valid), 0);
        end

        // Randomized run against the model
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 7) == 0) mask = N'($urandom);
            irq_ready = ($urandom_range(0, 2) != 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
